keccak_msg_feeder: RTL and testbench
====================================

KECCAK_MSG_FEEDER -- requirements
Module: keccak_msg_feeder

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, giving the width of the forwarded-byte counter.
REQ-002 SHALL use reset iRst, synchronous, active-high, and clock iClk.
REQ-003 Port list; this block sits upstream of the SHA3 core and drives its message input:
- iClk  in  1  clock
- iRst  in  1  sync active-high reset
- iWord  in  32  message word; first byte in [31:24]
- iWord_valid  in  1  word offered
- iWord_last  in  1  final word of the message
- iWord_bytes  in  3  valid bytes in the last word (0..4); ignored when iWord_last=0
- oWord_ready  out  1  word accepted when iWord_valid & oWord_ready
- iBuffer_full  in  1  core padder cannot take a beat
- oData  out  64  lane to core; first byte in [63:56]
- oReady  out  1  lane beat valid to core
- oLast  out  1  final beat
- oByte_num  out  3  valid bytes in the final beat (0..7)
- oByte_count  out  COUNT_W  message bytes forwarded so far
- oDone  out  1  final beat transferred

Function
REQ-004 SHALL pack two accepted words into one lane: the even-indexed word goes to [63:32] and the odd-indexed word to [31:0].
REQ-005 SHALL use states HI (expect even word), LO (expect odd word), SEND (lane held), EXTRA (empty last beat pending) and DONE.
REQ-006 Beat transfer (fire) SHALL occur when oReady=1; oReady = lane_valid & ~iBuffer_full, with no registered stage.
REQ-007 oLast SHALL be 1 only when oReady=1 and the held lane is final; oByte_num SHALL be 0 whenever oLast=0.
REQ-008 oWord_ready SHALL be (~lane_valid | fire) & ~DONE & ~EXTRA.
REQ-009 The lane SHALL become valid on the clock edge that accepts the completing word, so oReady can assert one cycle after acceptance.
REQ-010 Last word in HI with iWord_bytes=b SHALL produce a final lane with byte_num=b and [31:0] zeroed.
REQ-011 Last word in LO with b<4 SHALL produce a final lane with byte_num=4+b.
REQ-012 Last word in LO with b=4 SHALL produce a non-final full lane, then enter EXTRA, then emit a beat with oLast=1, oByte_num=0 and oData=0.
REQ-013 An iWord_bytes value of 5..7 on a last word SHALL be treated as 4.
REQ-014 Bytes beyond the valid count in a final lane SHALL be driven as zero.
REQ-015 While a lane is held and iBuffer_full=1, oData, oLast-qualification and oByte_num SHALL be stable and no word SHALL be accepted.
REQ-016 oByte_count SHALL add the valid byte count of each fired beat (8 for non-final beats, oByte_num for the final beat) and SHALL wrap modulo 2^COUNT_W.
REQ-017 After the final fire, the block SHALL enter DONE and set oDone=1.
REQ-018 DONE SHALL hold until iRst, with oWord_ready=0 and oReady=0.
REQ-019 If iWord_valid is asserted together with a fire, the new word SHALL be accepted in that same cycle.

Reset
REQ-020 On iRst, the state SHALL go to HI and lane_valid SHALL clear.
REQ-021 On iRst, oData=0, oReady=0, oLast=0, oByte_num=0, oByte_count=0, oDone=0 and oWord_ready=1 (from the next cycle).
REQ-022 iRst mid-message SHALL discard any partial lane; iRst has priority over every other event in the same cycle.

Structure
REQ-023 The state encoding and the constants WORD_W=32, LANE_W=64 and LANE_BYTES=8 SHALL live in a shared package, keccak_pkg.
REQ-024 The block SHALL be a single module with no sub-module; byte masking SHALL be implemented as a local function.

Verification
REQ-025 Empty message: one word, last=1, bytes=0 -> one beat with oData=0, oLast=1, oByte_num=0; then oDone=1 and oByte_count=0.
REQ-026 "abc": word 0x61626300, last, bytes=3 -> oData=0x6162630000000000, oByte_num=3, oLast=1, oByte_count=3.
REQ-027 8 bytes: words 0x01020304 and 0x05060708 (last, bytes=4) -> beat 0x0102030405060708 with oLast=0, then beat with oLast=1, oByte_num=0; oByte_count=8.
REQ-028 11 bytes in 3 words (last, bytes=3) -> full beat, then final beat with byte_num=3 and [31:8] of the high half plus [31:0] zero; oByte_count=11.
REQ-029 iBuffer_full=1 for 5 cycles with a lane held -> oReady=0, oLast=0, oData stable, oWord_ready=0; beat fires in the first cycle after iBuffer_full drops.
REQ-030 iRst after one even word accepted -> outputs at reset values; a following "abc" message reproduces the result of REQ-026 exactly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak message-feeding path.
package keccak_pkg;

    localparam int WORD_W     = 32;
    localparam int LANE_W     = 64;
    localparam int LANE_BYTES = 8;

    typedef enum logic [2:0] {
        ST_HI    = 3'd0,
        ST_LO    = 3'd1,
        ST_SEND  = 3'd2,
        ST_EXTRA = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/keccak_msg_feeder.sv
// Packs 32-bit message words into 64-bit lanes for the SHA3 core and tracks
// the byte count and final-beat qualification of the message.
module keccak_msg_feeder
    import keccak_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [31:0]        iWord,
    input  logic               iWord_valid,
    input  logic               iWord_last,
    input  logic [2:0]         iWord_bytes,
    output logic               oWord_ready,
    input  logic               iBuffer_full,
    output logic [63:0]        oData,
    output logic               oReady,
    output logic               oLast,
    output logic [2:0]         oByte_num,
    output logic [COUNT_W-1:0] oByte_count,
    output logic               oDone
);

    state_e               state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 lane_valid_q, lane_valid_d;
    logic                 lane_last_q, lane_last_d;
    logic [2:0]           lane_bytes_q, lane_bytes_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 fire;
    logic                 accept;
    logic [2:0]           word_b;
    logic [WORD_W-1:0]    word_m;

    function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

    // Keeps the first n bytes (MSB-first) of a word, zeroing the rest.
    function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] w,
                                                    input logic [2:0] n);
        case (n)
            3'd0:    return '0;
            3'd1:    return w & 32'hFF00_0000;
            3'd2:    return w & 32'hFFFF_0000;
            3'd3:    return w & 32'hFFFF_FF00;
            default: return w;
        endcase
    endfunction

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= ST_HI;
            lane_q       <= '0;
            lane_valid_q <= 1'b0;
            lane_last_q  <= 1'b0;
            lane_bytes_q <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            lane_valid_q <= lane_valid_d;
            lane_last_q  <= lane_last_d;
            lane_bytes_q <= lane_bytes_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        lane_valid_d = lane_valid_q;
        lane_last_d  = lane_last_q;
        lane_bytes_d = lane_bytes_q;
        count_d      = count_q;
        word_b       = clamp_bytes(iWord_bytes);
        word_m       = mask_word(iWord, word_b);

        if (fire) begin
            lane_valid_d = 1'b0;
            count_d = count_q + (lane_last_q ? COUNT_W'(lane_bytes_q) : COUNT_W'(LANE_BYTES));
        end

        case (state_q)
            ST_HI: begin
                // The held lane is released by this cycle's fire, so its
                // register can take the new even word immediately.
                if (accept) begin
                    if (iWord_last) begin
                        lane_d       = {word_m, {WORD_W{1'b0}}};
                        lane_valid_d = 1'b1;
                        lane_last_d  = 1'b1;
                        lane_bytes_d = word_b;
                        state_d      = ST_SEND;
                    end else begin
                        lane_d      = {iWord, {WORD_W{1'b0}}};
                        lane_last_d = 1'b0;
                        state_d     = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (accept) begin
                    lane_valid_d = 1'b1;
                    if (iWord_last && word_b != 3'd4) begin
                        lane_d[WORD_W-1:0] = word_m;
                        lane_last_d        = 1'b1;
                        lane_bytes_d       = 3'd4 + word_b;
                        state_d            = ST_SEND;
                    end else begin
                        lane_d[WORD_W-1:0] = iWord;
                        lane_last_d        = 1'b0;
                        state_d            = iWord_last ? ST_EXTRA : ST_HI;
                    end
                end
            end
            ST_SEND: begin
                if (fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_EXTRA: begin
                // First fire sends the full lane, then an empty final beat follows.
                if (fire) begin
                    if (lane_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        lane_d       = '0;
                        lane_valid_d = 1'b1;
                        lane_last_d  = 1'b1;
                        lane_bytes_d = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_HI;
            end
        endcase
    end

    always_comb begin
        fire        = lane_valid_q & ~iBuffer_full;
        oReady      = fire;
        oLast       = fire & lane_last_q;
        oByte_num   = oLast ? lane_bytes_q : 3'd0;
        oWord_ready = (~lane_valid_q | fire) & (state_q != ST_DONE) & (state_q != ST_EXTRA);
        accept      = iWord_valid & oWord_ready;
        oData       = lane_q;
        oByte_count = count_q;
        oDone       = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed bench for keccak_msg_feeder: an independent byte-level model fills
// a queue of expected beats that is drained whenever the DUT fires a beat.
module tb_keccak_msg_feeder;

    localparam int CW = 4;

    logic          iClk = 1'b0;
    logic          iRst;
    logic [31:0]   iWord;
    logic          iWord_valid;
    logic          iWord_last;
    logic [2:0]    iWord_bytes;
    logic          oWord_ready;
    logic          iBuffer_full;
    logic [63:0]   oData;
    logic          oReady;
    logic          oLast;
    logic [2:0]    oByte_num;
    logic [CW-1:0] oByte_count;
    logic          oDone;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [2:0]  num;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] msg_w [8];
    int          vectors = 0;
    int          miscompares = 0;
    logic        last_fire;
    logic        last_accept;
    logic        rand_bp = 1'b0;
    int          total;

    keccak_msg_feeder #(.COUNT_W(CW)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iWord       (iWord),
        .iWord_valid (iWord_valid),
        .iWord_last  (iWord_last),
        .iWord_bytes (iWord_bytes),
        .oWord_ready (oWord_ready),
        .iBuffer_full(iBuffer_full),
        .oData       (oData),
        .oReady      (oReady),
        .oLast       (oLast),
        .oByte_num   (oByte_num),
        .oByte_count (oByte_count),
        .oDone       (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, score any fired beat, then step past the edge.
    task automatic cyc();
        beat_t e;
        @(negedge iClk);
        last_fire   = oReady;
        last_accept = iWord_valid & oWord_ready;
        if (oReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", oData, e.data);
                check("beat_last", 64'(oLast), 64'(e.last));
                check("beat_num", 64'(oByte_num), 64'(e.num));
            end
        end else begin
            check("idle_last", 64'(oLast), 64'd0);
        end
        if (!oLast) check("num_gated", 64'(oByte_num), 64'd0);
        @(posedge iClk);
        #1;
        if (rand_bp) iBuffer_full = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rand_bp      = 1'b0;
        iRst         = 1'b1;
        iWord_valid  = 1'b0;
        iWord_last   = 1'b0;
        iWord_bytes  = 3'd0;
        iWord        = 32'd0;
        iBuffer_full = 1'b0;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        check("rst_data", oData, 64'd0);
        check("rst_oready", 64'(oReady), 64'd0);
        check("rst_last", 64'(oLast), 64'd0);
        check("rst_num", 64'(oByte_num), 64'd0);
        check("rst_count", 64'(oByte_count), 64'd0);
        check("rst_done", 64'(oDone), 64'd0);
        check("rst_wready", 64'(oWord_ready), 64'd1);
    endtask

    // Reference model: flatten words to bytes, then cut 8-byte beats.
    task automatic push_msg(input int nw, input int lb, output int tot);
        logic [7:0]  by [64];
        logic [31:0] w;
        beat_t       b;
        int          fb;
        int          nfull;
        fb  = (lb > 4) ? 4 : lb;
        tot = 4 * (nw - 1) + fb;
        for (int i = 0; i < 64; i++) by[i] = 8'd0;
        for (int i = 0; i < tot; i++) begin
            w     = msg_w[i / 4];
            by[i] = w[31 - 8 * (i % 4) -: 8];
        end
        nfull = tot / 8;
        for (int k = 0; k <= nfull; k++) begin
            for (int j = 0; j < 8; j++) b.data[63 - 8 * j -: 8] = by[8 * k + j];
            b.last = (k == nfull);
            b.num  = b.last ? 3'(tot % 8) : 3'd0;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input logic [2:0] nb);
        int n;
        iWord       = w;
        iWord_last  = last;
        iWord_bytes = last ? nb : 3'($urandom_range(0, 7));
        iWord_valid = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_accept && n < 64);
        if (!last_accept) check("accept_timeout", 64'd0, 64'd1);
        iWord_valid = 1'b0;
        iWord_last  = 1'b0;
    endtask

    task automatic finish_msg(input int tot);
        int n;
        n = 0;
        while (!oDone && n < 200) begin
            cyc();
            n++;
        end
        rand_bp      = 1'b0;
        iBuffer_full = 1'b0;
        check("done", 64'(oDone), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("byte_count", 64'(oByte_count), 64'(tot % (1 << CW)));
        iWord_valid = 1'b1;
        cyc();
        cyc();
        iWord_valid = 1'b0;
        check("done_hold", 64'(oDone), 64'd1);
        check("done_wready", 64'(oWord_ready), 64'd0);
        check("done_oready", 64'(oReady), 64'd0);
    endtask

    task automatic run_msg(input int nw, input int lb, input logic bp);
        int tot;
        do_reset();
        push_msg(nw, lb, tot);
        rand_bp = bp;
        for (int i = 0; i < nw; i++) send_word(msg_w[i], (i == nw - 1), 3'(lb));
        finish_msg(tot);
    endtask

    initial begin
        do_reset();
        check_reset_values();

        // Empty message; payload bytes must be masked away
        msg_w[0] = 32'hDEAD_BEEF;
        run_msg(1, 0, 1'b0);

        // "abc"
        msg_w[0] = 32'h6162_6300;
        run_msg(1, 3, 1'b0);

        // exactly 8 bytes -> full beat then empty final beat
        msg_w[0] = 32'h0102_0304;
        msg_w[1] = 32'h0506_0708;
        run_msg(2, 4, 1'b0);

        // 11 bytes, trailing garbage byte in last word
        msg_w[0] = 32'h0102_0304;
        msg_w[1] = 32'h0506_0708;
        msg_w[2] = 32'h090A_0BFF;
        run_msg(3, 3, 1'b0);

        // last word in LO with 2 bytes, and last word in HI with 4 bytes
        msg_w[0] = 32'hA1A2_A3A4;
        msg_w[1] = 32'hB1B2_B3B4;
        run_msg(2, 2, 1'b0);
        msg_w[0] = 32'hC1C2_C3C4;
        run_msg(1, 4, 1'b0);

        // byte count 6 clamps to 4; random backpressure
        for (int i = 0; i < 8; i++) msg_w[i] = $urandom;
        run_msg(7, 6, 1'b1);

        // 16 bytes with clamp from 5: count wraps to 0 in the narrow counter
        for (int i = 0; i < 8; i++) msg_w[i] = $urandom;
        run_msg(4, 5, 1'b1);

        // Held lane under backpressure, then fire and accept in the same cycle
        do_reset();
        msg_w[0] = 32'h1122_3344;
        msg_w[1] = 32'h5566_7788;
        msg_w[2] = 32'h99AA_BBCC;
        push_msg(3, 3, total);
        iBuffer_full = 1'b1;
        send_word(msg_w[0], 1'b0, 3'd0);
        send_word(msg_w[1], 1'b0, 3'd0);
        iWord       = msg_w[2];
        iWord_last  = 1'b1;
        iWord_bytes = 3'd3;
        iWord_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_accept", 64'(last_accept), 64'd0);
            check("bp_oready", 64'(oReady), 64'd0);
            check("bp_last", 64'(oLast), 64'd0);
            check("bp_wready", 64'(oWord_ready), 64'd0);
            check("bp_data", oData, 64'h1122_3344_5566_7788);
        end
        iBuffer_full = 1'b0;
        cyc();
        check("bp_fire", 64'(last_fire), 64'd1);
        check("bp_accept_with_fire", 64'(last_accept), 64'd1);
        iWord_valid = 1'b0;
        iWord_last  = 1'b0;
        finish_msg(total);

        // Reset after one even word, then "abc" again
        do_reset();
        send_word(32'hFEED_F00D, 1'b0, 3'd0);
        do_reset();
        check_reset_values();
        msg_w[0] = 32'h6162_6300;
        push_msg(1, 3, total);
        send_word(msg_w[0], 1'b1, 3'd3);
        finish_msg(total);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
